// File: rtl/segre_pkg.sv
// Shared types and constants for the segre RV32I decode stage.
package segre_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9,
    ALU_JAL  = 5'd10,
    ALU_JALR = 5'd11,
    ALU_BEQ  = 5'd12,
    ALU_BNE  = 5'd13,
    ALU_BLT  = 5'd14,
    ALU_BGE  = 5'd15,
    ALU_BLTU = 5'd16,
    ALU_BGEU = 5'd17
  } alu_opcode_e;

  // Encoded like funct3 of loads/stores: bit 2 is the unsigned flag.
  typedef enum logic [2:0] {
    MEM_BYTE  = 3'b000,
    MEM_HALF  = 3'b001,
    MEM_WORD  = 3'b010,
    MEM_BYTEU = 3'b100,
    MEM_HALFU = 3'b101
  } mem_size_e;

  function automatic alu_opcode_e base_alu_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/segre_imm_gen.sv
// Sign-extended immediate builder for all RV32I instruction formats.
module segre_imm_gen
  import segre_pkg::*;
(
  input  logic [31:0]          instr,
  output logic [WORD_SIZE-1:0] imm_i,
  output logic [WORD_SIZE-1:0] imm_s,
  output logic [WORD_SIZE-1:0] imm_b,
  output logic [WORD_SIZE-1:0] imm_u,
  output logic [WORD_SIZE-1:0] imm_j
);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/segre_decode.sv
// RV32I decode stage: classifies the instruction, selects ALU operands and
// registers the result into the ID/EX register with a valid/ready handshake.
module segre_decode
  import segre_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  if_valid_i,
  input  logic [31:0]           instr_i,
  input  logic [WORD_SIZE-1:0]  pc_i,
  output logic                  id_ready_o,
  output logic [REG_ADDR_W-1:0] rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rs2_addr_o,
  input  logic [WORD_SIZE-1:0]  rs1_data_i,
  input  logic [WORD_SIZE-1:0]  rs2_data_i,
  input  logic                  flush_i,
  input  logic                  ex_ready_i,
  output logic                  ex_valid_o,
  output alu_opcode_e           alu_opcode_o,
  output logic [WORD_SIZE-1:0]  alu_src_a_o,
  output logic [WORD_SIZE-1:0]  alu_src_b_o,
  output logic [WORD_SIZE-1:0]  rs1_val_o,
  output logic [WORD_SIZE-1:0]  rs2_val_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  rf_we_o,
  output logic                  mem_rd_o,
  output logic                  mem_wr_o,
  output mem_size_e             mem_size_o,
  output logic [WORD_SIZE-1:0]  link_o,
  output logic                  illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [REG_ADDR_W-1:0] rd;
  logic [WORD_SIZE-1:0] shamt_ext;
  logic [WORD_SIZE-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  alu_opcode_e          dec_op;
  logic [WORD_SIZE-1:0] dec_a, dec_b;
  logic                 dec_we, dec_mrd, dec_mwr, dec_ill;
  mem_size_e            dec_size;
  logic                 load;

  assign opcode     = instr_i[6:0];
  assign funct3     = instr_i[14:12];
  assign funct7     = instr_i[31:25];
  assign rd         = instr_i[11:7];
  assign shamt_ext  = {{(WORD_SIZE-5){1'b0}}, instr_i[24:20]};
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  assign id_ready_o = !ex_valid_o || ex_ready_i;
  assign load       = if_valid_i && id_ready_o;

  segre_imm_gen u_imm_gen (
    .instr (instr_i),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  always_comb begin
    dec_op   = ALU_ADD;
    dec_a    = rs1_data_i;
    dec_b    = imm_i;
    dec_we   = 1'b0;
    dec_mrd  = 1'b0;
    dec_mwr  = 1'b0;
    dec_size = MEM_WORD;
    dec_ill  = 1'b0;
    if (instr_i[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          dec_b  = rs2_data_i;
          dec_we = 1'b1;
          // funct7=0x20 is only meaningful for ADD/SUB and SRL/SRA
          if (funct7 == 7'h00) begin
            dec_op = base_alu_op(funct3);
          end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
            dec_op = ALU_SUB;
          end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
            dec_op = ALU_SRA;
          end else begin
            dec_ill = 1'b1;
          end
        end
        OPC_OP_IMM: begin
          dec_we = 1'b1;
          dec_op = base_alu_op(funct3);
          if (funct3 == 3'b001) begin
            dec_b   = shamt_ext;
            dec_ill = (funct7 != 7'h00);
          end else if (funct3 == 3'b101) begin
            dec_b   = shamt_ext;
            dec_op  = funct7[5] ? ALU_SRA : ALU_SRL;
            dec_ill = (funct7 != 7'h00) && (funct7 != 7'h20);
          end
        end
        OPC_LUI: begin
          dec_a  = '0;
          dec_b  = imm_u;
          dec_we = 1'b1;
        end
        OPC_AUIPC: begin
          dec_a  = pc_i;
          dec_b  = imm_u;
          dec_we = 1'b1;
        end
        OPC_JAL: begin
          dec_op = ALU_JAL;
          dec_a  = pc_i;
          dec_b  = imm_j;
          dec_we = 1'b1;
        end
        OPC_JALR: begin
          dec_op  = ALU_JALR;
          dec_we  = 1'b1;
          dec_ill = (funct3 != 3'b000);
        end
        OPC_BRANCH: begin
          dec_a = pc_i;
          dec_b = imm_b;
          case (funct3)
            3'b000:  dec_op = ALU_BEQ;
            3'b001:  dec_op = ALU_BNE;
            3'b100:  dec_op = ALU_BLT;
            3'b101:  dec_op = ALU_BGE;
            3'b110:  dec_op = ALU_BLTU;
            3'b111:  dec_op = ALU_BGEU;
            default: dec_ill = 1'b1;
          endcase
        end
        OPC_LOAD: begin
          dec_mrd = 1'b1;
          dec_we  = 1'b1;
          case (funct3)
            3'b000:  dec_size = MEM_BYTE;
            3'b001:  dec_size = MEM_HALF;
            3'b010:  dec_size = MEM_WORD;
            3'b100:  dec_size = MEM_BYTEU;
            3'b101:  dec_size = MEM_HALFU;
            default: dec_ill = 1'b1;
          endcase
        end
        OPC_STORE: begin
          dec_mwr = 1'b1;
          dec_b   = imm_s;
          case (funct3)
            3'b000:  dec_size = MEM_BYTE;
            3'b001:  dec_size = MEM_HALF;
            3'b010:  dec_size = MEM_WORD;
            default: dec_ill = 1'b1;
          endcase
        end
        default: dec_ill = 1'b1;
      endcase
    end
    // Illegal ops still travel to execute so it can trap, but without side effects
    if (dec_ill) begin
      dec_we  = 1'b0;
      dec_mrd = 1'b0;
      dec_mwr = 1'b0;
    end
    if (rd == '0) dec_we = 1'b0;
  end

  // ID/EX register boundary
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      ex_valid_o   <= 1'b0;
      alu_opcode_o <= ALU_ADD;
      alu_src_a_o  <= '0;
      alu_src_b_o  <= '0;
      rs1_val_o    <= '0;
      rs2_val_o    <= '0;
      rd_addr_o    <= '0;
      rf_we_o      <= 1'b0;
      mem_rd_o     <= 1'b0;
      mem_wr_o     <= 1'b0;
      mem_size_o   <= MEM_WORD;
      link_o       <= '0;
      illegal_o    <= 1'b0;
    end else begin
      if (flush_i)         ex_valid_o <= 1'b0;
      else if (load)       ex_valid_o <= 1'b1;
      else if (ex_ready_i) ex_valid_o <= 1'b0;
      if (load) begin
        alu_opcode_o <= dec_op;
        alu_src_a_o  <= dec_a;
        alu_src_b_o  <= dec_b;
        rs1_val_o    <= rs1_data_i;
        rs2_val_o    <= rs2_data_i;
        rd_addr_o    <= rd;
        rf_we_o      <= dec_we;
        mem_rd_o     <= dec_mrd;
        mem_wr_o     <= dec_mwr;
        mem_size_o   <= dec_size;
        link_o       <= pc_i + WORD_SIZE'(4);
        illegal_o    <= dec_ill;
      end
    end
  end

endmodule

// File: tb/tb_segre_decode.sv
// Directed-vector bench for segre_decode: table of decoded instructions plus
// hand-written stall, flush and reset sequences.
module tb_segre_decode;
  import segre_pkg::*;

  logic                  clk = 1'b0;
  logic                  rsn, if_valid, flush, ex_ready;
  logic [31:0]           instr;
  logic [WORD_SIZE-1:0]  pc, rs1_data, rs2_data;
  logic                  id_ready, ex_valid, rf_we, mem_rd, mem_wr, illegal;
  logic [REG_ADDR_W-1:0] rs1_addr, rs2_addr, rd_addr;
  logic [WORD_SIZE-1:0]  alu_src_a, alu_src_b, rs1_val, rs2_val, link;
  alu_opcode_e           alu_opcode;
  mem_size_e             mem_size;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  segre_decode dut (
    .clk_i        (clk),
    .rsn_i        (rsn),
    .if_valid_i   (if_valid),
    .instr_i      (instr),
    .pc_i         (pc),
    .id_ready_o   (id_ready),
    .rs1_addr_o   (rs1_addr),
    .rs2_addr_o   (rs2_addr),
    .rs1_data_i   (rs1_data),
    .rs2_data_i   (rs2_data),
    .flush_i      (flush),
    .ex_ready_i   (ex_ready),
    .ex_valid_o   (ex_valid),
    .alu_opcode_o (alu_opcode),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .rs1_val_o    (rs1_val),
    .rs2_val_o    (rs2_val),
    .rd_addr_o    (rd_addr),
    .rf_we_o      (rf_we),
    .mem_rd_o     (mem_rd),
    .mem_wr_o     (mem_wr),
    .mem_size_o   (mem_size),
    .link_o       (link),
    .illegal_o    (illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        chk_alu;
    alu_opcode_e op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        mrd;
    logic        mwr;
    logic        ill;
    mem_size_e   size;
  } vec_t;

  localparam int NV = 17;
  vec_t tv[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    instr    = i;
    pc       = p;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic [31:0] p,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic c, input alu_opcode_e op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic we, input logic mrd,
                              input logic mwr, input logic ill, input mem_size_e sz);
    vec_t v;
    v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2; v.chk_alu = c; v.op = op;
    v.a = a; v.b = b; v.rd = rd; v.we = we; v.mrd = mrd; v.mwr = mwr;
    v.ill = ill; v.size = sz;
    return v;
  endfunction

  initial begin
    tv[0]  = mk(32'hFFF08293, 32'h0,   32'h10,   32'h0, 1, ALU_ADD,  32'h10,   32'hFFFFFFFF, 5,  1, 0, 0, 0, MEM_WORD);
    tv[1]  = mk(32'h00208463, 32'h100, 32'h7,    32'h7, 1, ALU_BEQ,  32'h100,  32'h8,        8,  0, 0, 0, 0, MEM_WORD);
    tv[2]  = mk(32'h123451B7, 32'h0,   32'h55,   32'h0, 1, ALU_ADD,  32'h0,    32'h12345000, 3,  1, 0, 0, 0, MEM_WORD);
    tv[3]  = mk(32'h002081B3, 32'h0,   32'h5,    32'h9, 1, ALU_ADD,  32'h5,    32'h9,        3,  1, 0, 0, 0, MEM_WORD);
    tv[4]  = mk(32'h402081B3, 32'h0,   32'h5,    32'h9, 1, ALU_SUB,  32'h5,    32'h9,        3,  1, 0, 0, 0, MEM_WORD);
    tv[5]  = mk(32'h4030D313, 32'h0,   32'h80,   32'h0, 1, ALU_SRA,  32'h80,   32'h3,        6,  1, 0, 0, 0, MEM_WORD);
    tv[6]  = mk(32'h00812383, 32'h0,   32'h1000, 32'h0, 1, ALU_ADD,  32'h1000, 32'h8,        7,  1, 1, 0, 0, MEM_WORD);
    tv[7]  = mk(32'hFE512E23, 32'h0,   32'h2000, 32'hAB,1, ALU_ADD,  32'h2000, 32'hFFFFFFFC, 28, 0, 0, 1, 0, MEM_WORD);
    tv[8]  = mk(32'h00004083, 32'h0,   32'h0,    32'h0, 1, ALU_ADD,  32'h0,    32'h0,        1,  1, 1, 0, 0, MEM_BYTEU);
    tv[9]  = mk(32'h010000EF, 32'h200, 32'h0,    32'h0, 1, ALU_JAL,  32'h200,  32'h10,       1,  1, 0, 0, 0, MEM_WORD);
    tv[10] = mk(32'h00008067, 32'h0,   32'h300,  32'h0, 1, ALU_JALR, 32'h300,  32'h0,        0,  0, 0, 0, 0, MEM_WORD);
    tv[11] = mk(32'h00001217, 32'h400, 32'h0,    32'h0, 1, ALU_ADD,  32'h400,  32'h1000,     4,  1, 0, 0, 0, MEM_WORD);
    tv[12] = mk(32'hFE20EEE3, 32'h100, 32'h1,    32'h2, 1, ALU_BLTU, 32'h100,  32'hFFFFFFFC, 29, 0, 0, 0, 0, MEM_WORD);
    tv[13] = mk(32'h00000000, 32'h0,   32'h0,    32'h0, 0, ALU_ADD,  32'h0,    32'h0,        0,  0, 0, 0, 1, MEM_WORD);
    tv[14] = mk(32'h022081B3, 32'h0,   32'h1,    32'h2, 0, ALU_ADD,  32'h0,    32'h0,        3,  0, 0, 0, 1, MEM_WORD);
    tv[15] = mk(32'h0020A463, 32'h0,   32'h1,    32'h2, 0, ALU_ADD,  32'h0,    32'h0,        8,  0, 0, 0, 1, MEM_WORD);
    tv[16] = mk(32'h0000000F, 32'h0,   32'h0,    32'h0, 0, ALU_ADD,  32'h0,    32'h0,        0,  0, 0, 0, 1, MEM_WORD);

    rsn = 1'b1; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    step(); step();
    chk("reset ex_valid",  {31'b0, ex_valid}, 32'h0);
    chk("reset alu_op",    {27'b0, alu_opcode}, {27'b0, ALU_ADD});
    chk("reset mem_size",  {29'b0, mem_size}, {29'b0, MEM_WORD});
    chk("reset src_b",     alu_src_b, 32'h0);
    chk("reset link",      link, 32'h0);
    rsn = 1'b0;

    for (int k = 0; k < NV; k++) begin
      drive(tv[k].instr, tv[k].pc, tv[k].rs1, tv[k].rs2);
      if_valid = 1'b1;
      #1;
      chk($sformatf("v%0d rs1_addr", k), {27'b0, rs1_addr}, {27'b0, tv[k].instr[19:15]});
      chk($sformatf("v%0d rs2_addr", k), {27'b0, rs2_addr}, {27'b0, tv[k].instr[24:20]});
      step();
      chk($sformatf("v%0d ex_valid", k), {31'b0, ex_valid}, 32'h1);
      chk($sformatf("v%0d illegal", k),  {31'b0, illegal}, {31'b0, tv[k].ill});
      chk($sformatf("v%0d rf_we", k),    {31'b0, rf_we}, {31'b0, tv[k].we});
      chk($sformatf("v%0d mem_rd", k),   {31'b0, mem_rd}, {31'b0, tv[k].mrd});
      chk($sformatf("v%0d mem_wr", k),   {31'b0, mem_wr}, {31'b0, tv[k].mwr});
      chk($sformatf("v%0d rd", k),       {27'b0, rd_addr}, {27'b0, tv[k].rd});
      chk($sformatf("v%0d rs1_val", k),  rs1_val, tv[k].rs1);
      chk($sformatf("v%0d rs2_val", k),  rs2_val, tv[k].rs2);
      chk($sformatf("v%0d link", k),     link, tv[k].pc + 32'd4);
      if (tv[k].chk_alu) begin
        chk($sformatf("v%0d alu_op", k), {27'b0, alu_opcode}, {27'b0, tv[k].op});
        chk($sformatf("v%0d src_a", k),  alu_src_a, tv[k].a);
        chk($sformatf("v%0d src_b", k),  alu_src_b, tv[k].b);
        chk($sformatf("v%0d size", k),   {29'b0, mem_size}, {29'b0, tv[k].size});
      end
    end

    // Not loaded with execute ready: valid drops, payload holds
    if_valid = 1'b0;
    drive(32'h002081B3, 32'h0, 32'h0, 32'h0);
    step();
    chk("idle ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("idle illegal hold", {31'b0, illegal}, 32'h1);

    // Stall: ADDI held for three cycles while instr_i changes
    drive(32'hFFF08293, 32'h0, 32'h10, 32'h0);
    if_valid = 1'b1;
    step();
    ex_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      drive(32'h123451B7 + s * 32'h80, 32'h40, 32'h99, 32'h77);
      #1;
      chk($sformatf("stall%0d id_ready", s), {31'b0, id_ready}, 32'h0);
      step();
      chk($sformatf("stall%0d ex_valid", s), {31'b0, ex_valid}, 32'h1);
      chk($sformatf("stall%0d src_a", s), alu_src_a, 32'h10);
      chk($sformatf("stall%0d src_b", s), alu_src_b, 32'hFFFFFFFF);
      chk($sformatf("stall%0d rd", s), {27'b0, rd_addr}, 32'd5);
    end
    ex_ready = 1'b1;
    drive(32'h123451B7, 32'h0, 32'h0, 32'h0);
    #1;
    chk("unstall id_ready", {31'b0, id_ready}, 32'h1);
    step();
    chk("unstall src_b", alu_src_b, 32'h12345000);
    chk("unstall rd", {27'b0, rd_addr}, 32'd3);

    // Flush with a coinciding load, then flush during a stall
    flush = 1'b1;
    step();
    chk("flush load ex_valid", {31'b0, ex_valid}, 32'h0);
    flush = 1'b0;
    step();
    chk("reload ex_valid", {31'b0, ex_valid}, 32'h1);
    ex_ready = 1'b0;
    flush = 1'b1;
    step();
    chk("flush stall ex_valid", {31'b0, ex_valid}, 32'h0);
    flush = 1'b0;

    // Illegal encoding reaches execute, then reset mid-stall
    ex_ready = 1'b1;
    drive(32'h00000000, 32'h500, 32'h3, 32'h4);
    step();
    chk("ill ex_valid", {31'b0, ex_valid}, 32'h1);
    chk("ill flag", {31'b0, illegal}, 32'h1);
    chk("ill rf_we", {31'b0, rf_we}, 32'h0);
    drive(32'h00812383, 32'h600, 32'h1000, 32'h0);
    step();
    chk("pre-reset mem_rd", {31'b0, mem_rd}, 32'h1);
    ex_ready = 1'b0;
    rsn = 1'b1;
    step();
    chk("rst ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst src_a", alu_src_a, 32'h0);
    chk("rst rs1_val", rs1_val, 32'h0);
    chk("rst rd", {27'b0, rd_addr}, 32'h0);
    chk("rst mem_rd", {31'b0, mem_rd}, 32'h0);
    chk("rst rf_we", {31'b0, rf_we}, 32'h0);
    chk("rst link", link, 32'h0);
    chk("rst alu_op", {27'b0, alu_opcode}, {27'b0, ALU_ADD});
    chk("rst size", {29'b0, mem_size}, {29'b0, MEM_WORD});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
